// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and issues word reads to instruction memory over a req/ack handshake.
// Fetched words are presented to IF/ID as a valid-qualified stream.
// A one-entry skid buffer absorbs a word that returns while IF/ID is stalled and the output is full.
// Branch/jump redirects flush the stage. A request that is still outstanding at redirect time
// is drained in DROP, and its data is thrown away.
// Optional build macro IF_FETCH_PERF_EN adds the fetch_cnt / stall_cnt performance counters.
module if_fetch #(
  parameter int             S        = 32,
  parameter int             A        = 32,
  parameter logic [A-1:0]   RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  output logic           imem_req,
  output logic [A-1:0]   imem_addr,
  input  logic           imem_ack,
  input  logic [S-1:0]   imem_rdata,
  input  logic           stall,
  input  logic           redirect,
  input  logic [A-1:0]   redirect_pc,
  output logic [S-1:0]   if_inst,
  output logic [A-1:0]   if_pc,
  output logic           if_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]    fetch_cnt,
  output logic [31:0]    stall_cnt
`endif
);

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [A-1:0]   drop_addr_q, drop_addr_d;
  logic           skid_valid_q, skid_valid_d;
  logic [S-1:0]   skid_inst_q, skid_inst_d;
  logic [A-1:0]   skid_pc_q, skid_pc_d;
  logic           if_valid_q, if_valid_d;
  logic [S-1:0]   if_inst_q, if_inst_d;
  logic [A-1:0]   if_pc_q, if_pc_d;

  logic           req;
  logic           accepted;
  logic           consume;

  // Handshake-facing signals: request, address, accepted-ack and downstream consume
  always_comb begin
    req       = reset && (((state_q == FETCH) && !skid_valid_q) || (state_q == DROP));
    // While draining, the address must stay on the request that is still outstanding,
    // even though pc already holds the redirect target.
    imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    // An ack is meaningful only while a request is actually being driven.
    accepted  = req && imem_ack;
    consume   = if_valid_q && !stall;
  end

  assign imem_req = req;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;

  // Next-state and datapath update, in priority order: redirect, drain, fetch, skid drain, consume
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if_valid_d   = if_valid_q;
    if_inst_d    = if_inst_q;
    if_pc_d      = if_pc_q;

    if (redirect) begin
      // Flush everything in this stage. Same-cycle return data is discarded.
      // Redirect takes effect even when IF/ID is stalled.
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = redirect_pc & ~A'(3);
      if (req && !imem_ack) begin
        state_d = DROP;
        // On a second redirect while already draining, keep tracking the original request.
        if (state_q == FETCH) begin
          drop_addr_d = pc_q;
        end
      end else begin
        state_d = FETCH;
      end
    end else if ((state_q == DROP) && accepted) begin
      // Stale word from before the redirect: throw it away and resume fetching at pc.
      state_d = FETCH;
    end else if ((state_q == FETCH) && accepted) begin
      pc_d = pc_q + A'(4);
      if (!if_valid_q || consume) begin
        if_inst_d  = imem_rdata;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
      end else begin
        // Output is held by a stall, so park the word.
        // The request drops until the skid drains.
        skid_inst_d  = imem_rdata;
        skid_pc_d    = pc_q;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q && consume) begin
      if_inst_d    = skid_inst_q;
      if_pc_d      = skid_pc_q;
      if_valid_d   = 1'b1;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if_valid_d = 1'b0;
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_valid_q <= 1'b0;
      if_valid_q   <= 1'b0;
      if_inst_q    <= '0;
      if_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      if_valid_q   <= if_valid_d;
      if_inst_q    <= if_inst_d;
      if_pc_q      <= if_pc_d;
    end
  end

  // Data-only registers: contents are qualified by skid_valid_q / state_q, so no reset needed
  always_ff @(posedge clk) begin
    drop_addr_q <= drop_addr_d;
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counter next values: words written to output/skid, and cycles of valid output held by stall
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!redirect && (state_q == FETCH) && accepted) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (if_valid_q && stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Performance counters: cleared only by reset, never by redirect
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
